// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Coin change dispenser. It accepts a payout request in cents,
//               checks that the current 5c/10c inventory can cover it exactly,
//               and then ejects coins one at a time (10c first, then 5c)
//               through a request/acknowledge handshake with the coin
//               mechanism. The inventory can be restocked one coin per cycle
//               while idle.
//
// Ports       : clk          - single clock, rising edge
//               reset        - asynchronous active-low reset
//               req          - payout request (sampled in IDLE only)
//               req_amount   - cents owed, 0..60, sampled with req
//               load_en      - restock strobe, one coin per cycle (IDLE only)
//               load_val     - restock coin type (0 = 5c, 1 = 10c)
//               coin_ack     - coin mechanism ejected the requested coin
//               coin_out_en  - registered eject request, held until acked
//               coin_out_val - registered coin type to eject (0 = 5c, 1 = 10c)
//               busy         - high whenever the FSM is not in IDLE
//               done         - one-cycle pulse when a payout completes
//               err          - one-cycle pulse when a request is rejected
//               remaining    - cents still owed on the current payout
//               cnt5, cnt10  - coin inventory counts
//
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int INIT_5  = 4,
    parameter int INIT_10 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [5:0] req_amount,
    input  logic       load_en,
    input  logic       load_val,
    input  logic       coin_ack,
    output logic       coin_out_en,
    output logic       coin_out_val,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [5:0] remaining,
    output logic [3:0] cnt5,
    output logic [3:0] cnt10
);

    localparam logic [3:0] C_INIT_5     = 4'(INIT_5);
    localparam logic [3:0] C_INIT_10    = 4'(INIT_10);
    localparam logic [3:0] C_CNT_MAX    = 4'd15;
    localparam logic [5:0] C_MAX_AMOUNT = 6'd60;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CHECK    = 3'd1,
        ISSUE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_next;
    logic       r_check_phase;
    logic       w_check_phase_next;
    logic [5:0] r_need5;
    logic [5:0] w_need5_next;
    logic       r_coin_en;
    logic       w_coin_en_next;
    logic       r_coin_val;
    logic       w_coin_val_next;
    logic       r_done;
    logic       w_done_next;
    logic       r_err;
    logic       w_err_next;
    logic [5:0] r_remaining;
    logic [5:0] w_remaining_next;
    logic [3:0] r_cnt5;
    logic [3:0] w_cnt5_next;
    logic [3:0] r_cnt10;
    logic [3:0] w_cnt10_next;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic       w_amount_valid;
    logic [5:0] w_tens_wanted;
    logic [5:0] w_cnt10_ext;
    logic [5:0] w_n10;
    logic [5:0] w_rest;
    logic [5:0] w_need5;
    logic       w_sel10;
    logic [5:0] w_coin_cents;
    logic [5:0] w_rem_after;

    // A nonzero request is acceptable only if it is a whole number of
    // nickels and within the largest payout the block supports.
    assign w_amount_valid = (req_amount <= C_MAX_AMOUNT) &&
                            ((req_amount % 6'd5) == 6'd0);

    // Feasibility: use as many dimes as possible, then see whether the
    // nickels on hand cover the rest. Using fewer dimes can only increase
    // the nickels needed, so this single test decides feasibility.
    assign w_tens_wanted = r_remaining / 6'd10;
    assign w_cnt10_ext   = {2'b00, r_cnt10};
    assign w_n10         = (w_cnt10_ext < w_tens_wanted) ? w_cnt10_ext : w_tens_wanted;
    assign w_rest        = r_remaining - (w_n10 * 6'd10);
    assign w_need5       = w_rest / 6'd5;

    // Dimes go out first while they are useful and available.
    assign w_sel10 = (r_remaining >= 6'd10) && (r_cnt10 != 4'd0);

    assign w_coin_cents = r_coin_val ? 6'd10 : 6'd5;
    assign w_rem_after  = r_remaining - w_coin_cents;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_check_phase_next = r_check_phase;
        w_need5_next       = r_need5;
        w_coin_en_next     = r_coin_en;
        w_coin_val_next    = r_coin_val;
        w_done_next        = 1'b0;
        w_err_next         = 1'b0;
        w_remaining_next   = r_remaining;
        w_cnt5_next        = r_cnt5;
        w_cnt10_next       = r_cnt10;

        unique case (r_state)
            IDLE: begin
                // Restock and request may coincide; the updated counts are
                // what CHECK sees on the following cycles.
                if (load_en) begin
                    if (load_val) begin
                        if (r_cnt10 != C_CNT_MAX) begin
                            w_cnt10_next = r_cnt10 + 4'd1;
                        end
                    end else begin
                        if (r_cnt5 != C_CNT_MAX) begin
                            w_cnt5_next = r_cnt5 + 4'd1;
                        end
                    end
                end
                if (req) begin
                    if (req_amount == 6'd0) begin
                        w_done_next = 1'b1;
                    end else if (w_amount_valid) begin
                        w_remaining_next   = req_amount;
                        w_check_phase_next = 1'b0;
                        w_state_next       = CHECK;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end

            CHECK: begin
                // The divide/min arithmetic is registered in the first CHECK
                // cycle and the accept/reject decision is made in the second,
                // keeping the division off the path into the state register.
                if (!r_check_phase) begin
                    w_need5_next       = w_need5;
                    w_check_phase_next = 1'b1;
                end else begin
                    w_check_phase_next = 1'b0;
                    if (r_need5 <= {2'b00, r_cnt5}) begin
                        w_state_next = ISSUE;
                    end else begin
                        // Reject the whole payout; nothing has been ejected.
                        w_err_next       = 1'b1;
                        w_remaining_next = 6'd0;
                        w_state_next     = IDLE;
                    end
                end
            end

            ISSUE: begin
                w_coin_en_next  = 1'b1;
                w_coin_val_next = w_sel10;
                w_state_next    = WAIT_ACK;
            end

            WAIT_ACK: begin
                if (coin_ack && r_coin_en) begin
                    w_coin_en_next = 1'b0;
                    if (r_coin_val) begin
                        w_cnt10_next = r_cnt10 - 4'd1;
                    end else begin
                        w_cnt5_next = r_cnt5 - 4'd1;
                    end
                    w_remaining_next = w_rem_after;
                    if (w_rem_after == 6'd0) begin
                        // done is registered, so it is high during DONE.
                        w_done_next  = 1'b1;
                        w_state_next = DONE;
                    end else begin
                        w_state_next = ISSUE;
                    end
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_check_phase <= 1'b0;
            r_need5       <= 6'd0;
            r_coin_en     <= 1'b0;
            r_coin_val    <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_remaining   <= 6'd0;
            r_cnt5        <= C_INIT_5;
            r_cnt10       <= C_INIT_10;
        end else begin
            r_state       <= w_state_next;
            r_check_phase <= w_check_phase_next;
            r_need5       <= w_need5_next;
            r_coin_en     <= w_coin_en_next;
            r_coin_val    <= w_coin_val_next;
            r_done        <= w_done_next;
            r_err         <= w_err_next;
            r_remaining   <= w_remaining_next;
            r_cnt5        <= w_cnt5_next;
            r_cnt10       <= w_cnt10_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign coin_out_en  = r_coin_en;
    assign coin_out_val = r_coin_val;
    assign busy         = (r_state != IDLE);
    assign done         = r_done;
    assign err          = r_err;
    assign remaining    = r_remaining;
    assign cnt5         = r_cnt5;
    assign cnt10        = r_cnt10;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser. Three instances with
//               different starting inventories are exercised through directed
//               scenarios and a randomized sequence checked against a
//               behavioural payout model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int N_DUT = 3;
    localparam int C_INIT5  [N_DUT] = '{4, 2, 4};
    localparam int C_INIT10 [N_DUT] = '{4, 0, 1};

    logic       clk;
    logic       rst_n;
    logic       req_s      [N_DUT];
    logic [5:0] amt_s      [N_DUT];
    logic       load_en_s  [N_DUT];
    logic       load_val_s [N_DUT];
    logic       ack_s      [N_DUT];
    logic       en_s       [N_DUT];
    logic       val_s      [N_DUT];
    logic       busy_s     [N_DUT];
    logic       done_s     [N_DUT];
    logic       err_s      [N_DUT];
    logic [5:0] rem_s      [N_DUT];
    logic [3:0] c5_s       [N_DUT];
    logic [3:0] c10_s      [N_DUT];

    generate
        for (genvar g = 0; g < N_DUT; g++) begin : g_dut
            change_dispenser #(
                .INIT_5  (C_INIT5[g]),
                .INIT_10 (C_INIT10[g])
            ) u_dut (
                .clk          (clk),
                .reset        (rst_n),
                .req          (req_s[g]),
                .req_amount   (amt_s[g]),
                .load_en      (load_en_s[g]),
                .load_val     (load_val_s[g]),
                .coin_ack     (ack_s[g]),
                .coin_out_en  (en_s[g]),
                .coin_out_val (val_s[g]),
                .busy         (busy_s[g]),
                .done         (done_s[g]),
                .err          (err_s[g]),
                .remaining    (rem_s[g]),
                .cnt5         (c5_s[g]),
                .cnt10        (c10_s[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Behavioural inventory model per instance
    int m5  [N_DUT];
    int m10 [N_DUT];

    // Results gathered by the request driver
    int          res_ncoins;
    logic [15:0] res_coins;
    int          res_ndone;
    int          res_nerr;
    int          res_nbusy;
    bit          res_unstable;
    bit          res_nogap;
    bit          res_timeout;

    task automatic clear_inputs();
        for (int i = 0; i < N_DUT; i++) begin
            req_s[i]      = 1'b0;
            amt_s[i]      = 6'd0;
            load_en_s[i]  = 1'b0;
            load_val_s[i] = 1'b0;
            ack_s[i]      = 1'b0;
        end
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            m5[i]  = C_INIT5[i];
            m10[i] = C_INIT10[i];
        end
    endtask

    task automatic do_load(input int idx, input logic typ);
        load_en_s[idx]  = 1'b1;
        load_val_s[idx] = typ;
        @(posedge clk);
        #1;
        load_en_s[idx] = 1'b0;
        if (typ) m10[idx] = (m10[idx] >= 15) ? 15 : m10[idx] + 1;
        else     m5[idx]  = (m5[idx]  >= 15) ? 15 : m5[idx] + 1;
    endtask

    // Payout model: any mix of a dimes and b nickels with 10a + 5b = amt that
    // the inventory covers; dimes are preferred, so search from most dimes.
    task automatic model_request(input int idx, input int amt, output bit reject,
                                 output int n10, output int n5, output logic [15:0] exp_coins);
        bit found;
        reject = 1'b0; n10 = 0; n5 = 0; exp_coins = '0; found = 1'b0;
        if (amt == 0) begin
            reject = 1'b0;
        end else if (amt > 60 || (amt % 5) != 0) begin
            reject = 1'b1;
        end else begin
            for (int a = m10[idx]; a >= 0 && !found; a--) begin
                if (10 * a <= amt && (amt - 10 * a) / 5 <= m5[idx]) begin
                    found = 1'b1;
                    n10   = a;
                    n5    = (amt - 10 * a) / 5;
                end
            end
            if (found) begin
                m10[idx] -= n10;
                m5[idx]  -= n5;
                for (int i = 0; i < n10; i++) exp_coins[i] = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end
    endtask

    // Drives one request and plays the coin mechanism; records what it sees.
    task automatic do_request(input int idx, input logic [5:0] amount, input int smin,
                              input int smax, input bit noise, input bit with_load,
                              input logic load_type);
        bit   prev_en, prev_val, acked;
        int   stall, tail;
        prev_en = 1'b0; prev_val = 1'b0; acked = 1'b0; stall = 0; tail = 0;
        res_ncoins = 0; res_coins = '0; res_ndone = 0; res_nerr = 0; res_nbusy = 0;
        res_unstable = 1'b0; res_nogap = 1'b0;
        req_s[idx]      = 1'b1;
        amt_s[idx]      = amount;
        load_en_s[idx]  = with_load;
        load_val_s[idx] = load_type;
        @(posedge clk);
        #1;
        req_s[idx]     = 1'b0;
        load_en_s[idx] = 1'b0;
        for (int cyc = 0; cyc < 400 && tail < 3; cyc++) begin
            if (busy_s[idx]) res_nbusy++;
            if (done_s[idx]) res_ndone++;
            if (err_s[idx])  res_nerr++;
            if (prev_en && !en_s[idx] && !acked) res_unstable = 1'b1;
            if (en_s[idx]) begin
                if (acked) res_nogap = 1'b1;
                if (!prev_en || acked) begin
                    if (res_ncoins < 16) res_coins[res_ncoins] = val_s[idx];
                    res_ncoins++;
                    stall = $urandom_range(smax, smin);
                end else if (val_s[idx] !== prev_val) begin
                    res_unstable = 1'b1;
                end
            end
            acked      = 1'b0;
            ack_s[idx] = 1'b0;
            if (en_s[idx]) begin
                if (stall == 0) begin
                    ack_s[idx] = 1'b1;
                    acked      = 1'b1;
                end else begin
                    stall--;
                end
            end else if (noise) begin
                ack_s[idx] = 1'($urandom_range(1, 0));
            end
            req_s[idx]      = noise && busy_s[idx] && ($urandom_range(1, 0) == 1);
            amt_s[idx]      = 6'($urandom_range(12, 1) * 5);
            load_en_s[idx]  = noise && busy_s[idx] && ($urandom_range(1, 0) == 1);
            load_val_s[idx] = 1'($urandom_range(1, 0));
            prev_en  = en_s[idx];
            prev_val = val_s[idx];
            if (!busy_s[idx] && (res_ndone + res_nerr) > 0) tail++;
            @(posedge clk);
            #1;
        end
        res_timeout = (tail < 3);
        req_s[idx] = 1'b0; load_en_s[idx] = 1'b0; ack_s[idx] = 1'b0; amt_s[idx] = 6'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < N_DUT; i++) begin
            n_cmp++;
            if ({en_s[i], val_s[i], busy_s[i], done_s[i], err_s[i]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: got %b expected 00000", i,
                         {en_s[i], val_s[i], busy_s[i], done_s[i], err_s[i]});
            end
            n_cmp++;
            if (rem_s[i] !== 6'd0 || c5_s[i] !== 4'(C_INIT5[i]) || c10_s[i] !== 4'(C_INIT10[i])) begin
                n_fail++;
                $display("FAIL reset_counts[%0d]: got rem=%0d c5=%0d c10=%0d expected 0/%0d/%0d",
                         i, rem_s[i], c5_s[i], c10_s[i], C_INIT5[i], C_INIT10[i]);
            end
        end
    endtask

    task automatic test_exact_25();
        apply_reset();
        do_request(0, 6'd25, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (res_ncoins != 3 || res_coins !== 16'h0003) begin
            n_fail++;
            $display("FAIL pay25_coins: got n=%0d seq=%b expected n=3 seq=011", res_ncoins, res_coins[2:0]);
        end
        n_cmp++;
        if (res_ndone != 1 || res_nerr != 0) begin
            n_fail++;
            $display("FAIL pay25_pulses: got done=%0d err=%0d expected 1/0", res_ndone, res_nerr);
        end
        n_cmp++;
        if (c10_s[0] !== 4'd2 || c5_s[0] !== 4'd3 || rem_s[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL pay25_counts: got c10=%0d c5=%0d rem=%0d expected 2/3/0", c10_s[0], c5_s[0], rem_s[0]);
        end
        n_cmp++;
        if ({res_unstable, res_nogap, res_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL pay25_handshake: got unstable/nogap/timeout=%b expected 000",
                     {res_unstable, res_nogap, res_timeout});
        end
    endtask

    task automatic test_stall_30();
        apply_reset();
        do_request(0, 6'd30, 3, 3, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (res_ncoins != 3 || res_coins !== 16'h0007) begin
            n_fail++;
            $display("FAIL stall30_coins: got n=%0d seq=%b expected n=3 seq=111", res_ncoins, res_coins[2:0]);
        end
        n_cmp++;
        if ({res_unstable, res_nogap, res_timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall30_handshake: got unstable/nogap/timeout=%b expected 000",
                     {res_unstable, res_nogap, res_timeout});
        end
        n_cmp++;
        if (c10_s[0] !== 4'd1 || c5_s[0] !== 4'd4 || res_ndone != 1) begin
            n_fail++;
            $display("FAIL stall30_end: got c10=%0d c5=%0d done=%0d expected 1/4/1", c10_s[0], c5_s[0], res_ndone);
        end
    endtask

    task automatic test_infeasible();
        apply_reset();
        do_request(1, 6'd15, 0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (res_nerr != 1 || res_ndone != 0 || res_ncoins != 0) begin
            n_fail++;
            $display("FAIL infeasible_resp: got err=%0d done=%0d coins=%0d expected 1/0/0",
                     res_nerr, res_ndone, res_ncoins);
        end
        n_cmp++;
        if (res_nbusy != 2) begin
            n_fail++;
            $display("FAIL infeasible_busy: got %0d cycles expected 2", res_nbusy);
        end
        n_cmp++;
        if (c5_s[1] !== 4'd2 || c10_s[1] !== 4'd0 || rem_s[1] !== 6'd0) begin
            n_fail++;
            $display("FAIL infeasible_counts: got c5=%0d c10=%0d rem=%0d expected 2/0/0", c5_s[1], c10_s[1], rem_s[1]);
        end
    endtask

    task automatic test_mixed();
        apply_reset();
        do_request(2, 6'd30, 0, 2, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (res_ncoins != 5 || res_coins !== 16'h0001) begin
            n_fail++;
            $display("FAIL mixed_coins: got n=%0d seq=%b expected n=5 seq=00001", res_ncoins, res_coins[4:0]);
        end
        n_cmp++;
        if (res_ndone != 1 || c5_s[2] !== 4'd0 || c10_s[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL mixed_end: got done=%0d c5=%0d c10=%0d expected 1/0/0", res_ndone, c5_s[2], c10_s[2]);
        end
    endtask

    task automatic test_bad_amounts();
        int amts [5] = '{7, 0, 61, 63, 33};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            do_request(0, 6'(amts[k]), 0, 0, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (res_ndone != (amts[k] == 0 ? 1 : 0) || res_nerr != (amts[k] == 0 ? 0 : 1) || res_nbusy != 0) begin
                n_fail++;
                $display("FAIL bad_amount_%0d: got done=%0d err=%0d busy=%0d expected %0d/%0d/0",
                         amts[k], res_ndone, res_nerr, res_nbusy, amts[k] == 0, amts[k] != 0);
            end
            n_cmp++;
            if (c5_s[0] !== 4'd4 || c10_s[0] !== 4'd4 || rem_s[0] !== 6'd0 || res_ncoins != 0) begin
                n_fail++;
                $display("FAIL bad_amount_%0d_state: got c5=%0d c10=%0d rem=%0d coins=%0d expected 4/4/0/0",
                         amts[k], c5_s[0], c10_s[0], rem_s[0], res_ncoins);
            end
        end
    endtask

    task automatic test_load_saturate();
        apply_reset();
        for (int k = 0; k < 12; k++) do_load(0, 1'b0);
        n_cmp++;
        if (c5_s[0] !== 4'd15 || c10_s[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL load_saturate: got c5=%0d c10=%0d expected 15/4", c5_s[0], c10_s[0]);
        end
        do_load(0, 1'b1);
        n_cmp++;
        if (c10_s[0] !== 4'd5 || c5_s[0] !== 4'd15) begin
            n_fail++;
            $display("FAIL load_dime: got c10=%0d c5=%0d expected 5/15", c10_s[0], c5_s[0]);
        end
    endtask

    task automatic test_load_while_busy();
        apply_reset();
        do_request(0, 6'd20, 1, 2, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (c10_s[0] !== 4'd2 || c5_s[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL load_busy_counts: got c10=%0d c5=%0d expected 2/4", c10_s[0], c5_s[0]);
        end
        n_cmp++;
        if (res_ndone != 1 || res_nerr != 0 || res_ncoins != 2 || res_coins !== 16'h0003) begin
            n_fail++;
            $display("FAIL load_busy_payout: got done=%0d err=%0d coins=%0d expected 1/0/2",
                     res_ndone, res_nerr, res_ncoins);
        end
    endtask

    task automatic test_req_and_load();
        apply_reset();
        do_request(1, 6'd15, 0, 1, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (res_ncoins != 3 || res_coins !== 16'h0000 || res_ndone != 1 || res_nerr != 0) begin
            n_fail++;
            $display("FAIL req_load_nickel: got coins=%0d done=%0d err=%0d expected 3/1/0",
                     res_ncoins, res_ndone, res_nerr);
        end
        n_cmp++;
        if (c5_s[1] !== 4'd0 || c10_s[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL req_load_nickel_counts: got c5=%0d c10=%0d expected 0/0", c5_s[1], c10_s[1]);
        end
        do_request(2, 6'd20, 0, 1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (res_ncoins != 2 || res_coins !== 16'h0003 || c10_s[2] !== 4'd0 || c5_s[2] !== 4'd4) begin
            n_fail++;
            $display("FAIL req_load_dime: got coins=%0d seq=%b c10=%0d c5=%0d expected 2/11/0/4",
                     res_ncoins, res_coins[1:0], c10_s[2], c5_s[2]);
        end
    endtask

    task automatic test_random();
        bit          reject;
        int          n10, n5, amt, nloads;
        bit          wl;
        logic        lt;
        logic [15:0] exp_coins;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            nloads = $urandom_range(3, 0);
            for (int k = 0; k < nloads; k++) do_load(0, 1'($urandom_range(1, 0)));
            if ($urandom_range(4, 0) == 0) amt = $urandom_range(63, 0);
            else                           amt = $urandom_range(12, 0) * 5;
            wl = ($urandom_range(3, 0) == 0);
            lt = 1'($urandom_range(1, 0));
            if (wl) begin
                if (lt) m10[0] = (m10[0] >= 15) ? 15 : m10[0] + 1;
                else    m5[0]  = (m5[0]  >= 15) ? 15 : m5[0] + 1;
            end
            model_request(0, amt, reject, n10, n5, exp_coins);
            do_request(0, 6'(amt), 0, 3, 1'b1, wl, lt);
            n_cmp++;
            if (res_ncoins != n10 + n5 || res_coins !== exp_coins) begin
                n_fail++;
                $display("FAIL rand[%0d] amt=%0d coins: got n=%0d seq=%h expected n=%0d seq=%h",
                         it, amt, res_ncoins, res_coins, n10 + n5, exp_coins);
            end
            n_cmp++;
            if (res_ndone != (reject ? 0 : 1) || res_nerr != (reject ? 1 : 0)) begin
                n_fail++;
                $display("FAIL rand[%0d] amt=%0d pulses: got done=%0d err=%0d expected reject=%0d",
                         it, amt, res_ndone, res_nerr, reject);
            end
            n_cmp++;
            if (c5_s[0] !== 4'(m5[0]) || c10_s[0] !== 4'(m10[0]) || rem_s[0] !== 6'd0) begin
                n_fail++;
                $display("FAIL rand[%0d] amt=%0d counts: got c5=%0d c10=%0d rem=%0d expected %0d/%0d/0",
                         it, amt, c5_s[0], c10_s[0], rem_s[0], m5[0], m10[0]);
            end
            n_cmp++;
            if ({res_unstable, res_nogap, res_timeout} !== 3'b000) begin
                n_fail++;
                $display("FAIL rand[%0d] handshake: got unstable/nogap/timeout=%b expected 000",
                         it, {res_unstable, res_nogap, res_timeout});
            end
        end
    endtask

    task automatic test_reset_mid_payout();
        int seen;
        bit prev, got;
        apply_reset();
        seen = 0; prev = 1'b0; got = 1'b0;
        req_s[0] = 1'b1;
        amt_s[0] = 6'd30;
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            if (en_s[0] && !prev) seen++;
            if (seen == 2 && en_s[0]) got = 1'b1;
            ack_s[0] = en_s[0] && (seen == 1);
            prev = en_s[0];
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        ack_s[0] = 1'b0;
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL midreset_reach: got no second coin request expected one within 60 cycles");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({en_s[0], val_s[0], busy_s[0], done_s[0], err_s[0]} !== 5'b0 || rem_s[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got flags=%b rem=%0d expected 00000/0",
                     {en_s[0], val_s[0], busy_s[0], done_s[0], err_s[0]}, rem_s[0]);
        end
        n_cmp++;
        if (c5_s[0] !== 4'd4 || c10_s[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL midreset_counts: got c5=%0d c10=%0d expected 4/4", c5_s[0], c10_s[0]);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            m5[i]  = C_INIT5[i];
            m10[i] = C_INIT10[i];
        end
        n_cmp++;
        if (en_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_residual: got en=%b busy=%b expected 0/0", en_s[0], busy_s[0]);
        end
        do_request(0, 6'd10, 0, 1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (res_ncoins != 1 || res_coins !== 16'h0001 || res_ndone != 1 || c10_s[0] !== 4'd3 || c5_s[0] !== 4'd4) begin
            n_fail++;
            $display("FAIL midreset_newreq: got coins=%0d done=%0d c10=%0d c5=%0d expected 1/1/3/4",
                     res_ncoins, res_ndone, c10_s[0], c5_s[0]);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_exact_25();
        test_stall_30();
        test_infeasible();
        test_mixed();
        test_bad_amounts();
        test_load_saturate();
        test_load_while_busy();
        test_req_and_load();
        test_random();
        test_reset_mid_payout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have a parameter INIT_5, default 4, meaning the 5-cent coin inventory loaded at reset (0..15).
REQ-002 The block SHALL have a parameter INIT_10, default 4, meaning the 10-cent coin inventory loaded at reset (0..15).
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have the port req, input, 1 bit, an active-high payout request, sampled in IDLE only.
REQ-006 The block SHALL have the port req_amount, input, 6 bits, the cents owed (0..60), sampled with req.
REQ-007 The block SHALL have the port load_en, input, 1 bit, an active-high restock strobe, adding one coin per cycle.
REQ-008 The block SHALL have the port load_val, input, 1 bit, the restock coin type (0 = 5 cents, 1 = 10 cents).
REQ-009 The block SHALL have the port coin_ack, input, 1 bit, the coin mechanism's acknowledgement that the requested coin was ejected.
REQ-010 The block SHALL have the port coin_out_en, output, 1 bit, a registered eject request held until acknowledged.
REQ-011 The block SHALL have the port coin_out_val, output, 1 bit, the registered coin type to eject (0 = 5 cents, 1 = 10 cents).
REQ-012 The block SHALL have the port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-013 The block SHALL have the port done, output, 1 bit, a one-cycle pulse when a payout completes.
REQ-014 The block SHALL have the port err, output, 1 bit, a one-cycle pulse when a request is rejected.
REQ-015 The block SHALL have the ports remaining (6 bits, cents still owed), cnt5 (4 bits) and cnt10 (4 bits, inventory counts), all outputs.

Function
REQ-016 The block SHALL use the states IDLE, CHECK, ISSUE, WAIT_ACK and DONE.
REQ-017 In IDLE, req with req_amount a nonzero multiple of 5 and at most 60 SHALL latch remaining <= req_amount and move to CHECK.
REQ-018 In IDLE, req with req_amount = 0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-019 In IDLE, req with req_amount not a multiple of 5, or above 60, SHALL pulse err on the next cycle and stay in IDLE.
REQ-020 CHECK SHALL compute n10 = min(cnt10, remaining/10) and r = remaining - 10*n10.
REQ-021 If r/5 <= cnt5, CHECK SHALL move to ISSUE; otherwise it SHALL pulse err, clear remaining, move to IDLE and leave the inventory unchanged (no partial payout).
REQ-022 ISSUE SHALL select a 10-cent coin if remaining >= 10 and cnt10 > 0, and a 5-cent coin otherwise.
REQ-023 ISSUE SHALL set coin_out_en = 1 and coin_out_val to the selected coin, then move to WAIT_ACK.
REQ-024 In WAIT_ACK, coin_out_en and coin_out_val SHALL stay stable until coin_ack = 1.
REQ-025 On the acknowledging edge, the block SHALL:
- clear coin_out_en;
- decrement the matching inventory count;
- subtract 5 or 10 from remaining;
- go to DONE if the new remaining is 0, otherwise go to ISSUE.
REQ-026 Each coin SHALL take at least 2 cycles (ISSUE plus one WAIT_ACK cycle); coin_out_en SHALL be low for at least one cycle between coins.
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-028 req outside IDLE SHALL be ignored, with no queueing.
REQ-029 coin_ack while coin_out_en = 0 SHALL be ignored.
REQ-030 load_en SHALL be accepted in IDLE only and ignored otherwise.
REQ-031 An accepted load SHALL increment the selected count, saturating at 15.
REQ-032 If req and load_en occur in the same IDLE cycle, both SHALL take effect, and CHECK SHALL use the updated counts.
REQ-033 Inventory counts SHALL never underflow; the feasibility check in CHECK guarantees this.

Reset
REQ-034 Reset = 0 SHALL immediately force:
- state to IDLE;
- coin_out_en, coin_out_val, done, err and remaining to 0;
- cnt5 to INIT_5 and cnt10 to INIT_10.
REQ-035 Reset during WAIT_ACK SHALL abandon the payout; after release the block SHALL accept a new request with no residual coin request.

Verification
REQ-036 Default parameters, req with 25, ack one cycle after each coin_out_en -> coins 10, 10, 5; done pulses once; cnt10 = 2, cnt5 = 3, remaining = 0.
REQ-037 req with 30 and ack held off for 3 cycles per coin -> coin_out_en and coin_out_val stay stable through each stall; coins 10, 10, 10; cnt10 = 1.
REQ-038 INIT_10 = 0, INIT_5 = 2, req with 15 -> err pulse, no coin_out_en, counts unchanged, busy for exactly 2 cycles.
REQ-039 INIT_10 = 1, INIT_5 = 4, req with 30 -> coins 10, 5, 5, 5, 5; done pulses; counts end at 0/0.
REQ-040 The following SHALL each produce the stated response:
- req with 7 -> err pulse;
- req with 0 -> done pulse;
- 12 loads of 5-cent coins from the default state -> cnt5 saturates at 15;
- load_en while busy -> count unchanged.
REQ-041 Reset asserted mid-WAIT_ACK, after one of three coins -> all outputs cleared, counts back to INIT values; a new req with 10 completes normally.
